// File: rtl/bist_pkg.sv
// Shared definitions for the scan-BIST wrapper: controller states, scan geometry,
// the LFSR/MISR polynomial and the reference signature for the default configuration.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    localparam int SCAN_LEN = 6;

    // x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register: taps at bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int          DEF_N_PATTERNS = 32;
    localparam logic [15:0] DEF_LFSR_SEED  = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [4:0] d);
        return {s[14:0], ^(s & LFSR_TAPS)} ^ {11'd0, d};
    endfunction

    // Round-robin next state, packed as {ptr_next, grant_next}
    function automatic logic [5:0] arb_next(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] idx;
        logic [5:0] res;
        logic       found;
        res   = {ptr, 4'b0000};
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                res   = {idx + 2'd1, 4'b0001 << idx};
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Fault-free run of the whole test-per-scan session; chain[3:0]=grant, chain[5:4]=ptr,
    // chain[0] is the scan output. The CUT is cleared when a run starts.
    function automatic logic [15:0] calc_golden(input int n_patterns, input logic [15:0] seed);
        logic [15:0] lfsr;
        logic [15:0] misr;
        logic [5:0]  chain;
        lfsr  = seed;
        misr  = '0;
        chain = '0;
        for (int p = 0; p < n_patterns; p++) begin
            for (int s = 0; s < SCAN_LEN; s++) begin
                misr  = misr_step(misr, {chain[0], chain[3:0]});
                chain = {lfsr[15], chain[5:1]};
                lfsr  = lfsr_step(lfsr);
            end
            chain = arb_next(chain[5:4], lfsr[3:0]);
        end
        for (int s = 0; s < SCAN_LEN; s++) begin
            misr  = misr_step(misr, {chain[0], chain[3:0]});
            chain = {1'b0, chain[5:1]};
        end
        return misr;
    endfunction

    localparam logic [15:0] GOLDEN = calc_golden(DEF_N_PATTERNS, DEF_LFSR_SEED);

endpackage

// File: rtl/rr_arbiter4_scan.sv
// Four-requester round-robin arbiter whose six state flops double as one scan chain
// (scan in -> ptr[1], ptr[0], grant[3..0] -> scan out).
module rr_arbiter4_scan
    import bist_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_clear,
    input  logic       i_scan_en,
    input  logic       i_func_en,
    input  logic       i_scan_in,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic       o_scan_out
);

    logic [SCAN_LEN-1:0] w_state;
    logic [SCAN_LEN-1:0] w_shift_d;
    logic [SCAN_LEN-1:0] w_func_d;

    assign w_shift_d = {i_scan_in, w_state[SCAN_LEN-1:1]};
    assign w_func_d  = arb_next(w_state[5:4], i_req);

    genvar gi;
    generate
        for (gi = 0; gi < SCAN_LEN; gi++) begin : g_chain
            logic r_bit;
            always_ff @(posedge i_clk) begin
                if (i_srst || i_clear) begin
                    r_bit <= 1'b0;
                end else if (i_scan_en) begin
                    r_bit <= w_shift_d[gi];
                end else if (i_func_en) begin
                    r_bit <= w_func_d[gi];
                end
            end
            assign w_state[gi] = r_bit;
        end
    endgenerate

    assign o_grant    = w_state[3:0];
    assign o_scan_out = w_state[0];

endmodule

// File: rtl/top_level.sv
// Scan-BIST experiment chip top: round-robin arbiter CUT plus LFSR pattern source,
// MISR compactor and the test-per-scan controller.
module top_level
    import bist_pkg::*;
#(
    parameter int          N_PATTERNS = DEF_N_PATTERNS,
    parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED,
    parameter logic [15:0] GOLDEN_SIG = GOLDEN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bist_start,
    input  logic [3:0] pi,
    output logic       bist_end,
    output logic       pass_nfail,
    output logic [3:0] po
);

    localparam int             PAT_W      = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);
    localparam logic [2:0]     SHIFT_LAST = 3'(SCAN_LEN - 1);

    bist_state_t      r_state;
    bist_state_t      w_state_next;
    logic [15:0]      r_lfsr;
    logic [15:0]      r_misr;
    logic [2:0]       r_shift_cnt;
    logic [PAT_W-1:0] r_pat_cnt;
    logic             r_bist_end;
    logic             r_pass;

    logic             w_scan_en;
    logic             w_func_en;
    logic             w_cut_clear;
    logic             w_start;
    logic             w_scan_in;
    logic [3:0]       w_req;
    logic [3:0]       w_grant;
    logic             w_scan_out;
    logic             w_last_shift;

    assign w_last_shift = (r_shift_cnt == SHIFT_LAST);

    rr_arbiter4_scan u_cut (
        .i_clk      (clock),
        .i_srst     (reset),
        .i_clear    (w_cut_clear),
        .i_scan_en  (w_scan_en),
        .i_func_en  (w_func_en),
        .i_scan_in  (w_scan_in),
        .i_req      (w_req),
        .o_grant    (w_grant),
        .o_scan_out (w_scan_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The CUT is cleared on start so the signature never depends on pre-test traffic.
    always_comb begin
        w_state_next = r_state;
        w_scan_en    = 1'b0;
        w_func_en    = 1'b0;
        w_cut_clear  = 1'b0;
        w_start      = 1'b0;
        w_scan_in    = 1'b0;
        w_req        = pi;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_func_en = 1'b1;
                if (bist_start) begin
                    w_start      = 1'b1;
                    w_cut_clear  = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_scan_en = 1'b1;
                w_scan_in = r_lfsr[15];
                if (w_last_shift) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_func_en    = 1'b1;
                w_req        = r_lfsr[3:0];
                w_state_next = (r_pat_cnt == PAT_LAST) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                w_scan_en = 1'b1;
                if (w_last_shift) begin
                    w_state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_cut_clear  = 1'b1;
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr      <= LFSR_SEED;
            r_misr      <= '0;
            r_shift_cnt <= '0;
            r_pat_cnt   <= '0;
            r_bist_end  <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_start) begin
                r_lfsr      <= LFSR_SEED;
                r_misr      <= '0;
                r_shift_cnt <= '0;
                r_pat_cnt   <= '0;
                r_bist_end  <= 1'b0;
                r_pass      <= 1'b0;
            end
            if (r_state == ST_SHIFT) begin
                r_lfsr <= lfsr_step(r_lfsr);
            end
            if (w_scan_en) begin
                r_misr      <= misr_step(r_misr, {w_scan_out, w_grant});
                r_shift_cnt <= w_last_shift ? 3'd0 : r_shift_cnt + 3'd1;
            end
            if (r_state == ST_CAPTURE) begin
                r_pat_cnt <= r_pat_cnt + PAT_W'(1);
            end
            if (r_state == ST_COMPARE) begin
                r_pass     <= (r_misr == GOLDEN_SIG);
                r_bist_end <= 1'b1;
            end
        end
    end

    assign po         = w_grant;
    assign bist_end   = r_bist_end;
    assign pass_nfail = r_pass;

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: normal arbitration, clean/faulty BIST, abort and restart.
module tb_top_level;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       bist_start = 1'b0;
    logic [3:0] pi         = 4'b0000;
    logic       bist_end;
    logic       pass_nfail;
    logic [3:0] po;

    int n_checks = 0;
    int n_errors = 0;

    top_level dut (
        .clock      (clock),
        .reset      (reset),
        .bist_start (bist_start),
        .pi         (pi),
        .bist_end   (bist_end),
        .pass_nfail (pass_nfail),
        .po         (po)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bist_start = 1'b0;
        pi         = 4'b0000;
        step();
        step();
        reset = 1'b0;
    endtask

    // Pulses bist_start for one edge, then counts edges until bist_end (bounded).
    // A second bist_start pulse is injected after glitch_at edges (-1: none).
    task automatic run_bist(input int glitch_at, output int edges);
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        chk("start_clears_end", {31'd0, bist_end}, 32'd0);
        edges = 0;
        while (bist_end !== 1'b1 && edges < 400) begin
            bist_start = (edges == glitch_at) ? 1'b1 : 1'b0;
            step();
            edges++;
        end
        bist_start = 1'b0;
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         n_edges;

    initial begin
        // Reset state
        do_reset();
        chk("rst_po", {28'd0, po}, 32'd0);
        chk("rst_end", {31'd0, bist_end}, 32'd0);
        chk("rst_pass", {31'd0, pass_nfail}, 32'd0);

        // Single request and idle
        pi = 4'b0001; step();
        chk("single_req", {28'd0, po}, 32'h1);
        pi = 4'b0000; step();
        chk("no_req", {28'd0, po}, 32'h0);

        // Round-robin with all requesting
        do_reset();
        pi = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr_all_%0d", i), {28'd0, po}, {28'd0, rr_exp[i]});
        end

        // Priority rotation after a grant to index 2
        do_reset();
        pi = 4'b0100; step();
        chk("grant2", {28'd0, po}, 32'h4);
        pi = 4'b0101; step();
        chk("rot_from_ptr3", {28'd0, po}, 32'h1);
        step();
        chk("rot_from_ptr1", {28'd0, po}, 32'h4);

        // Clean BIST with requests active (ignored while running)
        do_reset();
        pi = 4'b1010;
        run_bist(-1, n_edges);
        chk("clean_edges", n_edges, 32'd231);
        chk("clean_pass", {31'd0, pass_nfail}, 32'd1);
        repeat (5) step();
        chk("clean_end_held", {31'd0, bist_end}, 32'd1);
        chk("clean_pass_held", {31'd0, pass_nfail}, 32'd1);

        // Restart from DONE with a stray bist_start mid-run
        run_bist(50, n_edges);
        chk("restart_edges", n_edges, 32'd231);
        chk("restart_pass", {31'd0, pass_nfail}, 32'd1);

        // Stuck-at-0 on the scan-out flop (grant[0])
        do_reset();
        force dut.u_cut.g_chain[0].r_bit = 1'b0;
        run_bist(-1, n_edges);
        chk("fault_edges", n_edges, 32'd231);
        chk("fault_end", {31'd0, bist_end}, 32'd1);
        chk("fault_pass", {31'd0, pass_nfail}, 32'd0);
        release dut.u_cut.g_chain[0].r_bit;

        // Abort with reset at edge 100, then a fresh run
        do_reset();
        pi         = 4'b0110;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        repeat (99) step();
        reset = 1'b1;
        step();
        chk("abort_po", {28'd0, po}, 32'd0);
        chk("abort_end", {31'd0, bist_end}, 32'd0);
        chk("abort_pass", {31'd0, pass_nfail}, 32'd0);
        reset = 1'b0;
        run_bist(-1, n_edges);
        chk("after_abort_edges", n_edges, 32'd231);
        chk("after_abort_pass", {31'd0, pass_nfail}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
